// File: rtl/hazard_bubble_stage.sv
// ID/EX register with load-use interlock: turns a load-use hazard into STALL_CYCLES bubbles.
// Latency is one cycle ID->EX. ext_stall freezes all state; flush beats every other event.
module hazard_bubble_stage #(
    parameter int CTRL_W       = 27,
    parameter int RA_W         = 5,
    parameter int LOAD_BIT     = 26,
    parameter int STALL_CYCLES = 1,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [CTRL_W-1:0] ctrl_in,
    input  logic [RA_W-1:0]   id_rd,
    input  logic [RA_W-1:0]   id_rs1,
    input  logic [RA_W-1:0]   id_rs2,
    input  logic              id_use_rs1,
    input  logic              id_use_rs2,
    input  logic              flush,
    input  logic              ext_stall,
    output logic [CTRL_W-1:0] ex_ctrl,
    output logic [RA_W-1:0]   ex_rd,
    output logic              pc_le,
    output logic              ifid_le,
    output logic              bubble,
    output logic              stalled,
    output logic [CNT_W-1:0]  bubble_cnt
);

    typedef enum logic {
        IDLE  = 1'b0,
        STALL = 1'b1
    } state_t;

    localparam logic [2:0] CNT_INIT = 3'(STALL_CYCLES - 1);

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        cnt;
    logic [2:0]        cnt_nxt;
    logic [CTRL_W-1:0] ex_ctrl_nxt;
    logic [RA_W-1:0]   ex_rd_nxt;
    logic              rs1_hit;
    logic              rs2_hit;
    logic              hazard;

    // A dual rs1/rs2 match collapses into one hazard; a load to x0 never interlocks.
    assign rs1_hit = id_use_rs1 && (id_rs1 == ex_rd);
    assign rs2_hit = id_use_rs2 && (id_rs2 == ex_rd);
    assign hazard  = (state == IDLE) && ex_ctrl[LOAD_BIT] && (ex_rd != '0)
                     && (rs1_hit || rs2_hit);

    assign stalled = (state == STALL);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= IDLE;
            cnt     <= 3'd0;
            ex_ctrl <= '0;
            ex_rd   <= '0;
        end else begin
            state   <= state_nxt;
            cnt     <= cnt_nxt;
            ex_ctrl <= ex_ctrl_nxt;
            ex_rd   <= ex_rd_nxt;
        end
    end

    // Priority: flush, ext_stall, STALL, hazard, normal. Reset masks the enables.
    always_comb begin
        state_nxt   = state;
        cnt_nxt     = cnt;
        ex_ctrl_nxt = ex_ctrl;
        ex_rd_nxt   = ex_rd;
        pc_le       = 1'b0;
        ifid_le     = 1'b0;
        bubble      = 1'b0;

        if (reset) begin
            state_nxt = IDLE;
        end else if (flush) begin
            state_nxt   = IDLE;
            cnt_nxt     = 3'd0;
            ex_ctrl_nxt = '0;
            ex_rd_nxt   = '0;
            pc_le       = 1'b1;
            ifid_le     = 1'b1;
            bubble      = 1'b1;
        end else if (ext_stall) begin
            state_nxt = state;
        end else if (state == STALL) begin
            ex_ctrl_nxt = '0;
            ex_rd_nxt   = '0;
            bubble      = 1'b1;
            cnt_nxt     = cnt - 3'd1;
            if (cnt <= 3'd1) begin
                state_nxt = IDLE;
            end
        end else if (hazard) begin
            ex_ctrl_nxt = '0;
            ex_rd_nxt   = '0;
            bubble      = 1'b1;
            if (STALL_CYCLES > 1) begin
                state_nxt = STALL;
                cnt_nxt   = CNT_INIT;
            end
        end else begin
            ex_ctrl_nxt = ctrl_in;
            ex_rd_nxt   = id_rd;
            pc_le       = 1'b1;
            ifid_le     = 1'b1;
        end
    end

    // Saturating bubble counter; sticks at all-ones.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            bubble_cnt <= '0;
        end else if (bubble && (bubble_cnt != {CNT_W{1'b1}})) begin
            bubble_cnt <= bubble_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_hazard_bubble_stage.sv
// Directed bench: three instances (1-cycle stall, 3-cycle stall, 4-bit counter) share stimulus.
module tb_hazard_bubble_stage;

    localparam logic [26:0] LOAD_CTRL = 27'h4000005;
    localparam logic [26:0] CONS_CTRL = 27'h0ABCDEF;
    localparam logic [26:0] PT_CTRL   = 27'h1234567;

    logic        clk = 1'b0;
    logic        reset;
    logic [26:0] ctrl_in;
    logic [4:0]  id_rd, id_rs1, id_rs2;
    logic        id_use_rs1, id_use_rs2, flush, ext_stall;

    logic [26:0] a_ex_ctrl, b_ex_ctrl, c_ex_ctrl;
    logic [4:0]  a_ex_rd, b_ex_rd, c_ex_rd;
    logic        a_pc_le, b_pc_le, c_pc_le;
    logic        a_ifid_le, b_ifid_le, c_ifid_le;
    logic        a_bubble, b_bubble, c_bubble;
    logic        a_stalled, b_stalled, c_stalled;
    logic [15:0] a_bubble_cnt, b_bubble_cnt;
    logic [3:0]  c_bubble_cnt;

    int n_tests = 0;
    int n_fail  = 0;

    always #5 clk = ~clk;

    hazard_bubble_stage #(.STALL_CYCLES(1)) a_dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .flush(flush),
        .ext_stall(ext_stall), .ex_ctrl(a_ex_ctrl), .ex_rd(a_ex_rd), .pc_le(a_pc_le),
        .ifid_le(a_ifid_le), .bubble(a_bubble), .stalled(a_stalled), .bubble_cnt(a_bubble_cnt));

    hazard_bubble_stage #(.STALL_CYCLES(3)) b_dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .flush(flush),
        .ext_stall(ext_stall), .ex_ctrl(b_ex_ctrl), .ex_rd(b_ex_rd), .pc_le(b_pc_le),
        .ifid_le(b_ifid_le), .bubble(b_bubble), .stalled(b_stalled), .bubble_cnt(b_bubble_cnt));

    hazard_bubble_stage #(.STALL_CYCLES(1), .CNT_W(4)) c_dut (
        .clk(clk), .reset(reset), .ctrl_in(ctrl_in), .id_rd(id_rd), .id_rs1(id_rs1),
        .id_rs2(id_rs2), .id_use_rs1(id_use_rs1), .id_use_rs2(id_use_rs2), .flush(flush),
        .ext_stall(ext_stall), .ex_ctrl(c_ex_ctrl), .ex_rd(c_ex_rd), .pc_le(c_pc_le),
        .ifid_le(c_ifid_le), .bubble(c_bubble), .stalled(c_stalled), .bubble_cnt(c_bubble_cnt));

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        ctrl_in = '0; id_rd = '0; id_rs1 = '0; id_rs2 = '0;
        id_use_rs1 = 0; id_use_rs2 = 0; flush = 0; ext_stall = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    // Put a load to x7 into EX, then present a consumer of x7 via rs2.
    task automatic load_then_consumer;
        ctrl_in = LOAD_CTRL; id_rd = 5'd7; id_use_rs1 = 0; id_use_rs2 = 0;
        tick();
        ctrl_in = CONS_CTRL; id_rd = 5'd9; id_rs2 = 5'd7; id_use_rs2 = 1;
        #1;
    endtask

    task automatic test_reset;
        reset = 1;
        ctrl_in = PT_CTRL; id_rd = 5'd5; flush = 1;
        tick();
        #1;
        n_tests++;
        if ({a_ex_ctrl, a_ex_rd, a_pc_le, a_ifid_le, a_bubble, a_stalled, a_bubble_cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_a: got ctrl=%0h rd=%0h pc=%0b if=%0b bub=%0b st=%0b cnt=%0d want all 0",
                a_ex_ctrl, a_ex_rd, a_pc_le, a_ifid_le, a_bubble, a_stalled, a_bubble_cnt);
        end
        n_tests++;
        if ({b_ex_ctrl, b_pc_le, b_bubble, b_stalled, b_bubble_cnt, b_dut.cnt} !== '0) begin
            n_fail++; $display("FAIL reset_outputs_b: got ctrl=%0h pc=%0b bub=%0b st=%0b cnt=%0d want all 0",
                b_ex_ctrl, b_pc_le, b_bubble, b_stalled, b_bubble_cnt);
        end
        idle_inputs();
        reset = 0;
    endtask

    task automatic test_pass_through;
        do_reset();
        ctrl_in = PT_CTRL; id_rd = 5'd5;
        #1;
        n_tests++;
        if (a_pc_le !== 1'b1 || a_ifid_le !== 1'b1 || a_bubble !== 1'b0) begin
            n_fail++; $display("FAIL pt_enables: got pc=%0b if=%0b bub=%0b want 1 1 0", a_pc_le, a_ifid_le, a_bubble);
        end
        tick();
        n_tests++;
        if (a_ex_ctrl !== PT_CTRL || a_ex_rd !== 5'd5) begin
            n_fail++; $display("FAIL pt_regs: got ctrl=%0h rd=%0d want 1234567 5", a_ex_ctrl, a_ex_rd);
        end
    endtask

    task automatic test_load_use_1;
        do_reset();
        load_then_consumer();
        n_tests++;
        if (a_pc_le !== 1'b0 || a_ifid_le !== 1'b0 || a_bubble !== 1'b1) begin
            n_fail++; $display("FAIL lu1_hazard: got pc=%0b if=%0b bub=%0b want 0 0 1", a_pc_le, a_ifid_le, a_bubble);
        end
        tick();
        n_tests++;
        if (a_ex_ctrl !== '0 || a_stalled !== 1'b0 || a_bubble_cnt !== 16'd1 || a_pc_le !== 1'b1) begin
            n_fail++; $display("FAIL lu1_bubble: got ctrl=%0h st=%0b cnt=%0d pc=%0b want 0 0 1 1",
                a_ex_ctrl, a_stalled, a_bubble_cnt, a_pc_le);
        end
        tick();
        n_tests++;
        if (a_ex_ctrl !== CONS_CTRL || a_ex_rd !== 5'd9 || a_bubble_cnt !== 16'd1) begin
            n_fail++; $display("FAIL lu1_resume: got ctrl=%0h rd=%0d cnt=%0d want abcdef 9 1", a_ex_ctrl, a_ex_rd, a_bubble_cnt);
        end
    endtask

    task automatic test_load_use_3;
        int lo = 0;
        int st = 0;
        do_reset();
        load_then_consumer();
        for (int i = 0; i < 8; i++) begin
            if (b_pc_le === 1'b1) break;
            lo++;
            if (b_stalled === 1'b1) st++;
            tick();
        end
        n_tests++;
        if (lo != 3 || st != 2 || b_bubble_cnt !== 16'd3) begin
            n_fail++; $display("FAIL lu3_counts: got pc_low=%0d stalled=%0d bubbles=%0d want 3 2 3", lo, st, b_bubble_cnt);
        end
        tick();
        n_tests++;
        if (b_ex_ctrl !== CONS_CTRL || b_ex_rd !== 5'd9) begin
            n_fail++; $display("FAIL lu3_resume: got ctrl=%0h rd=%0d want abcdef 9", b_ex_ctrl, b_ex_rd);
        end
    endtask

    task automatic test_flush_mid_stall;
        do_reset();
        load_then_consumer();
        tick();
        flush = 1;
        #1;
        n_tests++;
        if (b_pc_le !== 1'b1 || b_bubble !== 1'b1 || b_stalled !== 1'b1) begin
            n_fail++; $display("FAIL flush_comb: got pc=%0b bub=%0b st=%0b want 1 1 1", b_pc_le, b_bubble, b_stalled);
        end
        tick();
        flush = 0;
        #1;
        n_tests++;
        if (b_stalled !== 1'b0 || b_ex_ctrl !== '0 || b_bubble_cnt !== 16'd2 || b_dut.cnt !== 3'd0) begin
            n_fail++; $display("FAIL flush_after: got st=%0b ctrl=%0h bubbles=%0d cnt=%0d want 0 0 2 0",
                b_stalled, b_ex_ctrl, b_bubble_cnt, b_dut.cnt);
        end
    endtask

    task automatic test_ext_stall;
        int lo = 0;
        do_reset();
        load_then_consumer();
        tick();
        ext_stall = 1;
        for (int i = 0; i < 4; i++) begin
            #1;
            n_tests++;
            if (b_pc_le !== 1'b0 || b_bubble !== 1'b0) begin
                n_fail++; $display("FAIL xs_comb_%0d: got pc=%0b bub=%0b want 0 0", i, b_pc_le, b_bubble);
            end
            tick();
            n_tests++;
            if (b_ex_ctrl !== '0 || b_stalled !== 1'b1 || b_dut.cnt !== 3'd2 || b_bubble_cnt !== 16'd1) begin
                n_fail++; $display("FAIL xs_hold_%0d: got ctrl=%0h st=%0b cnt=%0d bubbles=%0d want 0 1 2 1",
                    i, b_ex_ctrl, b_stalled, b_dut.cnt, b_bubble_cnt);
            end
        end
        ext_stall = 0;
        #1;
        for (int i = 0; i < 8; i++) begin
            if (b_pc_le === 1'b1) break;
            lo++;
            tick();
        end
        n_tests++;
        if (lo != 2 || b_bubble_cnt !== 16'd3) begin
            n_fail++; $display("FAIL xs_total: got remaining=%0d bubbles=%0d want 2 3", lo, b_bubble_cnt);
        end
    endtask

    task automatic test_dual_and_x0;
        do_reset();
        ctrl_in = LOAD_CTRL; id_rd = 5'd7;
        tick();
        ctrl_in = CONS_CTRL; id_rd = 5'd9; id_rs1 = 5'd7; id_rs2 = 5'd7;
        id_use_rs1 = 1; id_use_rs2 = 1;
        tick();
        tick();
        n_tests++;
        if (a_bubble_cnt !== 16'd1 || a_ex_ctrl !== CONS_CTRL) begin
            n_fail++; $display("FAIL dual_hit: got bubbles=%0d ctrl=%0h want 1 abcdef", a_bubble_cnt, a_ex_ctrl);
        end
        do_reset();
        ctrl_in = LOAD_CTRL; id_rd = 5'd0;
        tick();
        ctrl_in = CONS_CTRL; id_rs1 = 5'd0; id_use_rs1 = 1;
        #1;
        n_tests++;
        if (b_pc_le !== 1'b1 || b_bubble !== 1'b0) begin
            n_fail++; $display("FAIL x0_load: got pc=%0b bub=%0b want 1 0", b_pc_le, b_bubble);
        end
    endtask

    task automatic test_saturation;
        do_reset();
        flush = 1;
        for (int i = 0; i < 14; i++) tick();
        n_tests++;
        if (c_bubble_cnt !== 4'd14) begin
            n_fail++; $display("FAIL sat_pre: got %0d want 14", c_bubble_cnt);
        end
        for (int i = 0; i < 6; i++) tick();
        n_tests++;
        if (c_bubble_cnt !== 4'd15 || b_bubble_cnt !== 16'd20) begin
            n_fail++; $display("FAIL sat_hold: got c=%0d b=%0d want 15 20", c_bubble_cnt, b_bubble_cnt);
        end
        flush = 0;
    endtask

    task automatic test_reset_mid_stall;
        do_reset();
        load_then_consumer();
        tick();
        tick();
        n_tests++;
        if (b_stalled !== 1'b1 || b_bubble_cnt !== 16'd2) begin
            n_fail++; $display("FAIL rms_pre: got st=%0b bubbles=%0d want 1 2", b_stalled, b_bubble_cnt);
        end
        #2;
        reset = 1;
        #1;
        n_tests++;
        if ({b_ex_ctrl, b_ex_rd, b_pc_le, b_ifid_le, b_bubble, b_stalled, b_bubble_cnt} !== '0) begin
            n_fail++; $display("FAIL rms_async: got ctrl=%0h pc=%0b bub=%0b st=%0b bubbles=%0d want all 0",
                b_ex_ctrl, b_pc_le, b_bubble, b_stalled, b_bubble_cnt);
        end
        tick();
        reset = 0;
        #1;
        n_tests++;
        if (b_pc_le !== 1'b1 || b_stalled !== 1'b0) begin
            n_fail++; $display("FAIL rms_release: got pc=%0b st=%0b want 1 0", b_pc_le, b_stalled);
        end
        tick();
        n_tests++;
        if (b_ex_ctrl !== CONS_CTRL || b_bubble_cnt !== 16'd0) begin
            n_fail++; $display("FAIL rms_flow: got ctrl=%0h bubbles=%0d want abcdef 0", b_ex_ctrl, b_bubble_cnt);
        end
    endtask

    initial begin
        idle_inputs();
        reset = 1;
        test_reset();
        test_pass_through();
        test_load_use_1();
        test_load_use_3();
        test_flush_mid_stall();
        test_ext_stall();
        test_dual_and_x0();
        test_saturation();
        test_reset_mid_stall();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
